ytydla_cmac_ctrl: RTL and testbench

Sequencer for the CMAC multiplier: it accepts a dot-product command of length N, streams N data/weight pairs into the registered multiplier, and accumulates the returned products. When all products have been summed, it presents one narrowed result on a valid/ready output. It sits between the ytydla operand fetch logic and the CMAC multiplier. It owns the multiplier's operand ports and tracks the multiplier's fixed one-cycle latency.

---
 rtl/ytydla_cmac_if.sv | 30 +++
 rtl/ytydla_cmac_ctrl.sv | 128 ++++++++++++
 tb/tb_ytydla_cmac_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ytydla_cmac_if.sv
// rtl/ytydla_cmac_if.sv - command, operand, multiplier and result signals of the CMAC sequencer
interface ytydla_cmac_if #(
   parameter int DATA_W = 16,
   parameter int LEN_W  = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [LEN_W-1:0]  cmd_len;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [DATA_W-1:0] in_weight;
   logic [DATA_W-1:0] mul_data;
   logic [DATA_W-1:0] mul_weight;
   logic [DATA_W-1:0] mul_result;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              busy;

   modport master (
      output cmd_valid, cmd_len, in_valid, in_data, in_weight, mul_result, out_ready,
      input  cmd_ready, in_ready, mul_data, mul_weight, out_valid, out_data, busy
   );

   modport slave (
      input  cmd_valid, cmd_len, in_valid, in_data, in_weight, mul_result, out_ready,
      output cmd_ready, in_ready, mul_data, mul_weight, out_valid, out_data, busy
   );
endinterface

// File: rtl/ytydla_cmac_ctrl.sv
// rtl/ytydla_cmac_ctrl.sv - dot-product sequencer around the one-cycle CMAC multiplier
// Define YTYDLA_CMAC_SAT_EN to saturate the narrowed result instead of wrapping it.
module ytydla_cmac_ctrl #(
   parameter int DATA_W = 16,
   parameter int LEN_W  = 8,
   parameter int ACC_W  = DATA_W + LEN_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          abort,
   ytydla_cmac_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t             state_q;
   logic [ACC_W-1:0]   acc_q;
   logic [ACC_W-1:0]   acc_d;
   logic [LEN_W-1:0]   cnt_q;
   logic               p_vld_q;
   logic               out_valid_q;
   logic [DATA_W-1:0]  out_data_q;
   logic [DATA_W-1:0]  narrow_d;
   logic               in_ready_q;
   logic               cmd_ready_q;
   logic               busy_q;
   logic               accept;

   // abort also gates the operands so nothing new enters the multiplier that cycle
   assign accept         = in_ready_q & bus.in_valid & ~abort;
   assign bus.mul_data   = accept ? bus.in_data   : '0;
   assign bus.mul_weight = accept ? bus.in_weight : '0;
   assign bus.in_ready   = in_ready_q;
   assign bus.cmd_ready  = cmd_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
   assign bus.busy       = busy_q;

   always_comb begin
      acc_d = acc_q;
      if (p_vld_q)
         acc_d = acc_q + {{(ACC_W-DATA_W){bus.mul_result[DATA_W-1]}}, bus.mul_result};
   end

`ifdef YTYDLA_CMAC_SAT_EN
   // in range exactly when the bits from the result sign bit upward all agree
   always_comb begin
      narrow_d = acc_d[DATA_W-1:0];
      if (!((acc_d[ACC_W-1:DATA_W-1] == '0) || (acc_d[ACC_W-1:DATA_W-1] == '1)))
         narrow_d = acc_d[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
   end
`else
   assign narrow_d = acc_d[DATA_W-1:0];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         p_vld_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         in_ready_q  <= 1'b0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
      end else if (abort) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         p_vld_q     <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         p_vld_q <= accept;
         case (state_q)
            IDLE: begin
               if (bus.cmd_valid && cmd_ready_q) begin
                  acc_q       <= '0;
                  cnt_q       <= bus.cmd_len;
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (bus.cmd_len == '0) begin
                     state_q     <= DONE;
                     out_valid_q <= 1'b1;
                     out_data_q  <= '0;
                  end else begin
                     state_q    <= RUN;
                     in_ready_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (accept) begin
                  cnt_q <= cnt_q - LEN_W'(1);
                  if (cnt_q == LEN_W'(1)) begin
                     state_q    <= DRAIN;
                     in_ready_q <= 1'b0;
                  end
               end
            end
            DRAIN: begin
               // the last product lands this cycle, so capture the sum including it
               state_q     <= DONE;
               out_valid_q <= 1'b1;
               out_data_q  <= narrow_d;
            end
            DONE: begin
               if (bus.out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
               cmd_ready_q <= 1'b1;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ytydla_cmac_ctrl.sv
// tb/tb_ytydla_cmac_ctrl.sv - directed bench for the CMAC sequencer with a Q8.8 multiplier model
module tb_ytydla_cmac_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic abort = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic signed [31:0] prod;
   logic [15:0] ovf_exp;

   ytydla_cmac_if #(.DATA_W(16), .LEN_W(8)) bus ();

   ytydla_cmac_ctrl #(.DATA_W(16), .LEN_W(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .abort (abort),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // registered Q8.8 multiplier: one cycle latency
   assign prod = $signed(bus.mul_data) * $signed(bus.mul_weight);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) bus.mul_result <= '0;
      else     bus.mul_result <= prod[23:8];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_out(input string tag, input int exp_cyc);
      for (int k = 0; k < 40 && !bus.out_valid; k++) tick();
      chk(tag, cyc, exp_cyc);
   endtask

   task automatic take_result();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_len = '0; bus.in_valid = 1'b0;
      bus.in_data = '0; bus.in_weight = '0; bus.out_ready = 1'b0;
`ifdef YTYDLA_CMAC_SAT_EN
      ovf_exp = 16'h7FFF;
`else
      ovf_exp = 16'h0000;
`endif
      #12;
      chk("rst_cmd_ready", bus.cmd_ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_mul_data", bus.mul_data, 0);
      rst = 1'b0;
      tick();

      // basic N=3
      bus.cmd_valid = 1'b1; bus.cmd_len = 8'd3; cyc = 0;
      tick();
      bus.cmd_valid = 1'b0;
      chk("basic_in_ready", bus.in_ready, 1);
      chk("basic_cmd_ready", bus.cmd_ready, 0);
      bus.in_valid = 1'b1; bus.in_data = 16'h0100; bus.in_weight = 16'h0200;
      #1;
      chk("basic_mul_data", bus.mul_data, 16'h0100);
      chk("basic_mul_weight", bus.mul_weight, 16'h0200);
      tick();
      bus.in_data = 16'h0200; bus.in_weight = 16'h0100;
      tick();
      bus.in_data = 16'hFF00; bus.in_weight = 16'h0100;
      tick();
      bus.in_valid = 1'b0;
      chk("basic_drain_in_ready", bus.in_ready, 0);
      chk("basic_drain_out_valid", bus.out_valid, 0);
      chk("basic_drain_busy", bus.busy, 1);
      wait_out("basic_latency", 5);
      chk("basic_out_data", bus.out_data, 16'h0300);
      take_result();
      chk("basic_after_out_valid", bus.out_valid, 0);
      chk("basic_after_cmd_ready", bus.cmd_ready, 1);

      // zero length
      bus.cmd_valid = 1'b1; bus.cmd_len = 8'd0; bus.in_valid = 1'b1; cyc = 0;
      tick();
      bus.cmd_valid = 1'b0;
      chk("zero_in_ready", bus.in_ready, 0);
      chk("zero_mul_data", bus.mul_data, 0);
      chk("zero_out_valid_c1", bus.out_valid, 1);
      chk("zero_out_data", bus.out_data, 0);
      bus.in_valid = 1'b0;
      take_result();

      // stall: in_valid 0,1,0,1,...
      bus.cmd_valid = 1'b1; bus.cmd_len = 8'd4; cyc = 0;
      tick();
      bus.cmd_valid = 1'b0;
      bus.in_data = 16'h0100; bus.in_weight = 16'h0100;
      for (int i = 0; i < 8; i++) begin
         bus.in_valid = (i % 2) == 1;
         tick();
      end
      bus.in_valid = 1'b0;
      wait_out("stall_latency", 10);
      chk("stall_out_data", bus.out_data, 16'h0400);
      bus.cmd_valid = 1'b1; bus.cmd_len = 8'd1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_out_data", bus.out_data, 16'h0400);
         chk("hold_out_valid", bus.out_valid, 1);
         chk("hold_cmd_ready", bus.cmd_ready, 0);
      end
      take_result();
      bus.cmd_valid = 1'b0;
      chk("hold_no_cmd_in_handshake", bus.busy, 0);

      // overflow: 4 x 0x4000
      bus.cmd_valid = 1'b1; bus.cmd_len = 8'd4; cyc = 0;
      tick();
      bus.cmd_valid = 1'b0;
      bus.in_valid = 1'b1; bus.in_data = 16'h4000; bus.in_weight = 16'h0100;
      for (int i = 0; i < 4; i++) tick();
      bus.in_valid = 1'b0;
      wait_out("ovf_latency", 6);
      chk("ovf_out_data", bus.out_data, ovf_exp);
      take_result();

      // abort mid-run, with a competing command in the abort cycle
      bus.cmd_valid = 1'b1; bus.cmd_len = 8'd5; cyc = 0;
      tick();
      bus.cmd_valid = 1'b0;
      bus.in_valid = 1'b1; bus.in_data = 16'h0200; bus.in_weight = 16'h0300;
      tick();
      tick();
      abort = 1'b1; bus.cmd_valid = 1'b1; bus.cmd_len = 8'd1;
      #1;
      chk("abort_mul_gated", bus.mul_data, 0);
      tick();
      abort = 1'b0; bus.cmd_valid = 1'b0; bus.in_valid = 1'b0;
      chk("abort_busy", bus.busy, 0);
      chk("abort_cmd_ready", bus.cmd_ready, 1);
      chk("abort_in_ready", bus.in_ready, 0);
      for (int i = 0; i < 4; i++) begin
         chk("abort_out_valid", bus.out_valid, 0);
         tick();
      end

      // clean N=1 after abort
      bus.cmd_valid = 1'b1; bus.cmd_len = 8'd1; cyc = 0;
      tick();
      bus.cmd_valid = 1'b0;
      bus.in_valid = 1'b1; bus.in_data = 16'h0100; bus.in_weight = 16'h0300;
      tick();
      bus.in_valid = 1'b0;
      wait_out("post_abort_latency", 3);
      chk("post_abort_out_data", bus.out_data, 16'h0300);

      // async reset while DONE
      chk("pre_rst_out_valid", bus.out_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", bus.out_valid, 0);
      chk("arst_busy", bus.busy, 0);
      chk("arst_out_data", bus.out_data, 0);
      chk("arst_cmd_ready", bus.cmd_ready, 1);
      rst = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
